// File: rtl/ibex_mem_resp_pkg.sv
// Shared types and constants for the Ibex data-memory responder.
// The optional stall generator is enabled by IBEX_MEM_RESP_STALL_LFSR_EN.
package ibex_mem_resp_pkg;

   // One queued response: read data (zero for writes and errors) plus bus error flag.
   typedef struct packed {
      logic [31:0] rdata;
      logic        err;
   } resp_entry_t;

   // 16-bit Fibonacci LFSR, taps 16,14,13,11 -> bit positions 15,13,12,10.
   localparam logic [15:0] LfsrSeed    = 16'hACE1;
   localparam logic [15:0] LfsrTapMask = 16'hB400;

   // Shift left; feedback is the XOR of the tapped bits.
   function automatic logic [15:0] lfsr_step(input logic [15:0] state);
      return {state[14:0], ^(state & LfsrTapMask)};
   endfunction

endpackage

// File: rtl/ibex_mem_resp_fifo.sv
// In-order response queue. Push and pop may happen in the same cycle; a push
// while full is accepted only if the head is popped on the same edge.
module ibex_mem_resp_fifo
   import ibex_mem_resp_pkg::*;
#(
   parameter int unsigned Depth = 2,
   localparam int unsigned CntW = $clog2(Depth + 1)
) (
   input  logic            clk_i,
   input  logic            rst_ni,
   input  logic            push_i,
   input  resp_entry_t     push_data_i,
   input  logic            pop_i,
   output logic            full_o,
   output logic            empty_o,
   output logic [CntW-1:0] count_o,
   output resp_entry_t     head_o
);

   localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
   localparam logic [PtrW-1:0] LastPtr   = PtrW'(Depth - 1);
   localparam logic [CntW-1:0] FullCount = CntW'(Depth);

   resp_entry_t           store_q [Depth];
   logic [PtrW-1:0]       wr_ptr_q, wr_ptr_d;
   logic [PtrW-1:0]       rd_ptr_q, rd_ptr_d;
   logic [CntW-1:0]       count_q, count_d;
   logic                  do_push;
   logic                  do_pop;

   // Wrap explicitly so non-power-of-two depths work.
   function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] ptr);
      return (ptr == LastPtr) ? '0 : ptr + 1'b1;
   endfunction

   assign full_o  = (count_q == FullCount);
   assign empty_o = (count_q == '0);
   assign count_o = count_q;
   assign head_o  = store_q[rd_ptr_q];

   assign do_pop  = pop_i && !empty_o;
   assign do_push = push_i && (!full_o || do_pop);

   // Next-state for pointers and occupancy.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) begin
         wr_ptr_d = ptr_inc(wr_ptr_q);
      end
      if (do_pop) begin
         rd_ptr_d = ptr_inc(rd_ptr_q);
      end
      if (do_push && !do_pop) begin
         count_d = count_q + 1'b1;
      end else if (!do_push && do_pop) begin
         count_d = count_q - 1'b1;
      end
   end

   // Control state; reset discards every queued entry.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Entry storage needs no reset: validity is tracked by count_q alone.
   always_ff @(posedge clk_i) begin
      if (do_push) begin
         store_q[wr_ptr_q] <= push_data_i;
      end
   end

endmodule

// File: rtl/ibex_data_mem_responder.sv
// Ibex-style data memory responder: word-addressed backing store with a
// combinational grant and fixed latency-1, in-order responses.
// Define IBEX_MEM_RESP_STALL_LFSR_EN to add pseudo-random grant stalls.
module ibex_data_mem_responder
   import ibex_mem_resp_pkg::*;
#(
   parameter int unsigned MemWords  = 256,
   parameter int unsigned RespDepth = 2,
   localparam int unsigned CntW     = $clog2(RespDepth + 1)
) (
   input  logic            clk_i,
   input  logic            rst_ni,
   input  logic            data_req_i,
   output logic            data_gnt_o,
   input  logic [31:0]     data_addr_i,
   input  logic            data_we_i,
   input  logic [3:0]      data_be_i,
   input  logic [31:0]     data_wdata_i,
   output logic            data_rvalid_o,
   output logic [31:0]     data_rdata_o,
   output logic            data_err_o,
   output logic [CntW-1:0] outstanding_o
);

   localparam int unsigned IdxW = (MemWords > 1) ? $clog2(MemWords) : 1;
   localparam logic [29:0]     MemWordsW  = 30'(MemWords);
   localparam logic [CntW-1:0] RespDepthC = CntW'(RespDepth);

   logic [31:0]     mem_q [MemWords];
   logic [29:0]     word_idx;
   logic [IdxW-1:0] mem_idx;
   logic            in_range;
   logic            accept;
   logic            stall;
   logic [31:0]     rd_word;
   resp_entry_t     push_entry;
   resp_entry_t     head_entry;
   logic            fifo_full;
   logic            fifo_empty;
   logic [CntW-1:0] fifo_count;
   logic            unused_addr_lsbs;

   assign word_idx         = data_addr_i[31:2];
   assign mem_idx          = word_idx[IdxW-1:0];
   assign in_range         = (word_idx < MemWordsW);
   assign unused_addr_lsbs = ^data_addr_i[1:0];

`ifdef IBEX_MEM_RESP_STALL_LFSR_EN
   logic [15:0] lfsr_q;

   // Free-running stall generator; restarts from the seed on every reset.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         lfsr_q <= LfsrSeed;
      end else begin
         lfsr_q <= lfsr_step(lfsr_q);
      end
   end

   assign stall = (lfsr_q[1:0] == 2'b00);
`else
   assign stall = 1'b0;
`endif

   // Full means full before any pop this cycle, so a pop never frees a slot early.
   assign data_gnt_o = rst_ni && data_req_i && (fifo_count != RespDepthC) && !stall;
   assign accept     = data_req_i && data_gnt_o;

   assign rd_word = mem_q[mem_idx];

   // Build the response for the request being accepted this cycle.
   always_comb begin
      push_entry = '{rdata: 32'h0, err: 1'b0};
      if (!in_range) begin
         push_entry.err = 1'b1;
      end else if (!data_we_i) begin
         push_entry.rdata = rd_word;
      end
   end

   // Byte-masked write; memory contents survive reset.
   always_ff @(posedge clk_i) begin
      if (accept && data_we_i && in_range) begin
         for (int b = 0; b < 4; b++) begin
            if (data_be_i[b]) begin
               mem_q[mem_idx][8*b +: 8] <= data_wdata_i[8*b +: 8];
            end
         end
      end
   end

   ibex_mem_resp_fifo #(
      .Depth (RespDepth)
   ) u_resp_fifo (
      .clk_i       (clk_i),
      .rst_ni      (rst_ni),
      .push_i      (accept),
      .push_data_i (push_entry),
      .pop_i       (!fifo_empty),
      .full_o      (fifo_full),
      .empty_o     (fifo_empty),
      .count_o     (fifo_count),
      .head_o      (head_entry)
   );

   // No backpressure: the head is presented and retired in the same cycle.
   always_comb begin
      data_rvalid_o = !fifo_empty;
      data_rdata_o  = 32'h0;
      data_err_o    = 1'b0;
      if (data_rvalid_o) begin
         data_rdata_o = head_entry.rdata;
         data_err_o   = head_entry.err;
      end
   end

   assign outstanding_o = fifo_count;

   logic unused_fifo_full;
   assign unused_fifo_full = fifo_full;

endmodule

// File: tb/tb_ibex_data_mem_responder.sv
// Randomized self-checking bench for ibex_data_mem_responder with a
// transaction-level model (associative memory + response queue).
module tb_ibex_data_mem_responder;

   localparam int unsigned MemWords  = 256;
   localparam int unsigned RespDepth = 2;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req = 1'b0;
   logic        gnt;
   logic [31:0] addr = '0;
   logic        we = 1'b0;
   logic [3:0]  be = '0;
   logic [31:0] wdata = '0;
   logic        rvalid;
   logic [31:0] rdata;
   logic        err;
   logic [1:0]  outstanding;

   always #5 clk = ~clk;

   ibex_data_mem_responder #(
      .MemWords  (MemWords),
      .RespDepth (RespDepth)
   ) dut (
      .clk_i         (clk),
      .rst_ni        (rst_n),
      .data_req_i    (req),
      .data_gnt_o    (gnt),
      .data_addr_i   (addr),
      .data_we_i     (we),
      .data_be_i     (be),
      .data_wdata_i  (wdata),
      .data_rvalid_o (rvalid),
      .data_rdata_o  (rdata),
      .data_err_o    (err),
      .outstanding_o (outstanding)
   );

   typedef struct {
      logic [31:0] rdata;
      logic        err;
   } exp_t;

   logic [31:0] mem_m [int unsigned];
   exp_t        q_m [$];
   logic [15:0] lfsr_m = 16'hACE1;
   int          n_checks = 0;
   int          n_errors = 0;

   logic        o_gnt, o_rvalid, o_err;
   logic [31:0] o_rdata;
   logic [1:0]  o_out;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // One clock: drive at posedge+1, compare at negedge, advance model, step.
   task automatic cycle(input logic r, input logic w, input logic [31:0] a,
                        input logic [3:0] b, input logic [31:0] d);
      logic        e_stall, e_gnt;
      int unsigned idx;
      exp_t        e;
      req = r; we = w; addr = a; be = b; wdata = d;
      if (!rst_n) begin
         q_m.delete();
         lfsr_m = 16'hACE1;
      end
      @(negedge clk);
`ifdef IBEX_MEM_RESP_STALL_LFSR_EN
      e_stall = (lfsr_m % 4 == 0);
`else
      e_stall = 1'b0;
`endif
      e_gnt = rst_n && r && (q_m.size() != RespDepth) && !e_stall;
      chk("gnt", gnt, e_gnt);
      chk("rvalid", rvalid, q_m.size() > 0);
      chk("rdata", rdata, q_m.size() > 0 ? q_m[0].rdata : 32'h0);
      chk("err", err, q_m.size() > 0 ? q_m[0].err : 1'b0);
      chk("outstanding", outstanding, q_m.size());
      o_gnt = gnt; o_rvalid = rvalid; o_rdata = rdata; o_err = err; o_out = outstanding;
      if (q_m.size() > 0) void'(q_m.pop_front());
      if (e_gnt) begin
         idx = a >> 2;
         e.rdata = 32'h0;
         e.err   = 1'b0;
         if (idx >= MemWords) begin
            e.err = 1'b1;
         end else if (w) begin
            for (int k = 0; k < 4; k++)
               if (b[k]) mem_m[idx][8*k +: 8] = d[8*k +: 8];
         end else begin
            e.rdata = mem_m[idx];
         end
         q_m.push_back(e);
      end
      if (rst_n) lfsr_m = {lfsr_m[14:0], lfsr_m[15] ^ lfsr_m[13] ^ lfsr_m[12] ^ lfsr_m[10]};
      @(posedge clk);
      #1;
   endtask

   // Retry until granted (bounded), then let its response come out.
   task automatic do_req(input string name, input logic w, input logic [31:0] a,
                         input logic [3:0] b, input logic [31:0] d);
      int tries = 0;
      do begin
         cycle(1'b1, w, a, b, d);
         tries++;
      end while (!o_gnt && tries < 40);
      chk({name, "_granted"}, o_gnt, 1'b1);
      cycle(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
   endtask

   initial begin
      logic [31:0] a;
      // Reset: outputs forced low even with req asserted.
      rst_n = 1'b0;
      for (int i = 0; i < 3; i++) begin
         cycle(1'b1, 1'b1, 32'h10, 4'hF, 32'hDEAD_BEEF);
         chk("rst_gnt_lit", o_gnt, 1'b0);
         chk("rst_out_lit", o_out, 2'd0);
      end
      rst_n = 1'b1;
      cycle(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);

      for (int i = 0; i < 8; i++)
         do_req("init", 1'b1, 32'(i * 4), 4'hF, $urandom);

      // Basic write/read with hand-computed expectations.
      do_req("wr10", 1'b1, 32'h10, 4'hF, 32'h1122_3344);
      chk("wr10_rvalid_lit", o_rvalid, 1'b1);
      chk("wr10_rdata_lit", o_rdata, 32'h0);
      chk("wr10_err_lit", o_err, 1'b0);
      do_req("rd10", 1'b0, 32'h10, 4'hF, 32'h0);
      chk("rd10_rdata_lit", o_rdata, 32'h1122_3344);
      do_req("wr10b", 1'b1, 32'h12, 4'b0100, 32'hAABB_CCDD);
      do_req("rd10b", 1'b0, 32'h10, 4'hF, 32'h0);
      chk("rd10b_rdata_lit", o_rdata, 32'h11BB_3344);
      do_req("rd400", 1'b0, 32'h400, 4'hF, 32'h0);
      chk("rd400_err_lit", o_err, 1'b1);
      chk("rd400_rdata_lit", o_rdata, 32'h0);
      do_req("wr400", 1'b1, 32'h400, 4'hF, 32'h5555_5555);
      chk("wr400_err_lit", o_err, 1'b1);
      do_req("rd10c", 1'b0, 32'h10, 4'hF, 32'h0);
      chk("rd10c_rdata_lit", o_rdata, 32'h11BB_3344);

`ifndef IBEX_MEM_RESP_STALL_LFSR_EN
      // Back-to-back: grant every cycle, occupancy settles at one.
      for (int i = 0; i < 4; i++) begin
         cycle(1'b1, 1'b0, 32'h10, 4'hF, 32'h0);
         chk("b2b_gnt_lit", o_gnt, 1'b1);
         if (i > 0) begin
            chk("b2b_out_lit", o_out, 2'd1);
            chk("b2b_rdata_lit", o_rdata, 32'h11BB_3344);
         end
      end
      cycle(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
      chk("b2b_last_rvalid_lit", o_rvalid, 1'b1);
`endif

      // Reset with a response in flight.
      cycle(1'b1, 1'b0, 32'h4, 4'hF, 32'h0);
      rst_n = 1'b0;
      cycle(1'b1, 1'b0, 32'h8, 4'hF, 32'h0);
      chk("midrst_rvalid_lit", o_rvalid, 1'b0);
      chk("midrst_out_lit", o_out, 2'd0);
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         cycle(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
         chk("postrst_rvalid_lit", o_rvalid, 1'b0);
      end

      // Randomized traffic over words 0..7 plus out-of-range addresses.
      for (int i = 0; i < 1500; i++) begin
         case ($urandom_range(0, 15))
            13:      a = 32'h0000_0400;
            14:      a = 32'h0000_07FC;
            15:      a = 32'hFFFF_FFFC;
            default: a = ($urandom_range(0, 7) << 2) | $urandom_range(0, 3);
         endcase
         if (i == 700) rst_n = 1'b0;
         if (i == 703) rst_n = 1'b1;
         cycle($urandom_range(0, 9) < 7, $urandom_range(0, 1) == 1, a,
               4'($urandom_range(0, 15)), $urandom);
      end
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++)
         cycle(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
